// File: rtl/uart_tx_io_pkg.sv
// Shared definitions for the uart_tx_io peripheral: register map, STATUS layout,
// transmitter FSM encoding and default line timing.
package uart_tx_io_pkg;

  localparam int DEFAULT_CLK_FREQ_HZ = 23_000_000;
  localparam int DEFAULT_BAUD        = 115_200;

  // Register offsets selected by ALU_result[3:2]
  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // STATUS word layout
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_COUNT_LSB = 3;
  localparam int STAT_COUNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per bit, rounded to nearest
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter. Pushes while full and pops while
// empty are ignored; the caller decides what those mean.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a FIFO through IOWrite
// and polls a STATUS word through IORead.
module uart_tx_io
  import uart_tx_io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD        = DEFAULT_BAUD,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_cs,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [1:0]  io_addr,
  input  logic [31:0] write_data,
  output logic [15:0] read_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int BW  = $clog2(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overrun;

  logic          push_req;
  logic          clear_req;
  logic          fifo_pop;
  logic          bit_end;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          unused_write_bits;

  assign push_req  = uart_cs && io_write && (io_addr == ADDR_TXDATA);
  assign clear_req = uart_cs && io_write && (io_addr == ADDR_CTRL) && write_data[0];
  assign bit_end   = (baud_cnt == BW'(DIV - 1));
  // The next frame is pulled either straight from idle or on the final stop-bit cycle.
  assign fifo_pop  = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign tx_busy   = (state != ST_IDLE) || !empty;

  assign unused_write_bits = ^write_data[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (write_data[7:0]),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            shift    <= head;
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!empty) begin
              shift <= head;
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A dropped push outranks a same-edge clear so the loss is never hidden.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (push_req && full) begin
      overrun <= 1'b1;
    end else if (clear_req) begin
      overrun <= 1'b0;
    end
  end

  // NOTE: read_data gets a default first so this combinational block cannot infer a latch.
  always_comb begin
    read_data = '0;
    if (uart_cs && io_read && (io_addr == ADDR_STATUS)) begin
      read_data[STAT_FULL]    = full;
      read_data[STAT_EMPTY]   = empty;
      read_data[STAT_OVERRUN] = overrun;
      read_data[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Self-checking bench for uart_tx_io at DIV=10: frames are decoded off the tx pin
// and compared with the bytes the bench pushed.
module tb_uart_tx_io;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD_HZ = 100_000;
  localparam int DEPTH   = 16;
  localparam int DIV     = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        uart_cs = 1'b0;
  logic        io_write = 1'b0;
  logic        io_read = 1'b0;
  logic [1:0]  io_addr = 2'd0;
  logic [31:0] write_data = 32'd0;
  logic [15:0] read_data;
  logic        tx;
  logic        tx_busy;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  uart_tx_io #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_HZ),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .uart_cs    (uart_cs),
    .io_write   (io_write),
    .io_read    (io_read),
    .io_addr    (io_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // One bus write; the store lands on the next rising edge, returns 1ns after it.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    uart_cs    = 1'b1;
    io_write   = 1'b1;
    io_addr    = a;
    write_data = $urandom();
    write_data[7:0] = d;
    @(posedge clock);
    #1;
    uart_cs    = 1'b0;
    io_write   = 1'b0;
    io_addr    = 2'd0;
    write_data = 32'd0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [15:0] v);
    uart_cs = 1'b1;
    io_read = 1'b1;
    io_addr = a;
    #1;
    v = read_data;
    uart_cs = 1'b0;
    io_read = 1'b0;
    io_addr = 2'd0;
  endtask

  task automatic wait_cycle(input int unsigned target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Decode one 8N1 frame; call 1ns after the edge that drove the start bit.
  // shape_ok requires every DIV-cycle bit window to be constant, start=0, stop=1.
  task automatic receive_frame(output logic [7:0] got, output logic shape_ok);
    logic [9:0] bits;
    logic       first;
    shape_ok = 1'b1;
    for (int slot = 0; slot < 10; slot++) begin
      first = tx;
      for (int j = 0; j < DIV; j++) begin
        if (tx !== first) shape_ok = 1'b0;
        @(posedge clock);
        #1;
      end
      bits[slot] = first;
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) shape_ok = 1'b0;
    got = bits[8:1];
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: tx_busy=%b expected 0", tx_busy); end
    checks++;
    if (read_data !== 16'h0000) begin failures++; $display("FAIL reset_rdata: read_data=0x%04h expected 0x0000", read_data); end
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0002) begin failures++; $display("FAIL reset_status: status=0x%04h expected 0x0002", v); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cpu_read(2'd3, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL unmapped_read: read_data=0x%04h expected 0x0000", v); end
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0002) begin failures++; $display("FAIL post_reset_status: status=0x%04h expected 0x0002", v); end
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [7:0] got;
    logic       ok;
    cpu_write(2'd0, b);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      failures++; $display("FAIL single_push_edge: tx=%b busy=%b expected tx=1 busy=1", tx, tx_busy);
    end
    @(posedge clock);
    #1;
    receive_frame(got, ok);
    checks++;
    if (got !== b || ok !== 1'b1) begin
      failures++; $display("FAIL single_frame: got=0x%02h shape=%b expected 0x%02h shape=1", got, ok, b);
    end
    checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      failures++; $display("FAIL single_idle: busy=%b tx=%b expected busy=0 tx=1", tx_busy, tx);
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0]  got;
    logic        ok;
    logic [15:0] v;
    cpu_write(2'd0, b0);
    cpu_write(2'd0, b1);
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0008) begin failures++; $display("FAIL b2b_status: status=0x%04h expected 0x0008", v); end
    receive_frame(got, ok);
    checks++;
    if (got !== b0 || ok !== 1'b1) begin
      failures++; $display("FAIL b2b_first: got=0x%02h shape=%b expected 0x%02h shape=1", got, ok, b0);
    end
    receive_frame(got, ok);
    checks++;
    if (got !== b1 || ok !== 1'b1) begin
      failures++; $display("FAIL b2b_second: got=0x%02h shape=%b expected 0x%02h shape=1", got, ok, b1);
    end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: tx_busy=%b expected 0", tx_busy); end
  endtask

  task automatic test_overflow();
    logic [7:0]  q [17];
    logic [7:0]  got;
    logic        ok;
    logic [15:0] v;
    int unsigned start;
    foreach (q[i]) q[i] = 8'($urandom());
    cpu_write(2'd0, q[0]);
    start = cyc + 1;
    for (int i = 1; i < 17; i++) cpu_write(2'd0, q[i]);
    // First byte left for the line at once; the other 16 fill the FIFO exactly.
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0081) begin failures++; $display("FAIL ovf_full: status=0x%04h expected 0x0081", v); end
    cpu_write(2'd0, 8'($urandom()));
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0085) begin failures++; $display("FAIL ovf_overrun: status=0x%04h expected 0x0085", v); end
    cpu_write(2'd2, 8'h00);
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0085) begin failures++; $display("FAIL ovf_ctrl0: status=0x%04h expected 0x0085", v); end
    cpu_write(2'd2, 8'h01);
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0081) begin failures++; $display("FAIL ovf_clear: status=0x%04h expected 0x0081", v); end
    cpu_read(2'd0, v);
    checks++;
    if (v !== 16'h0000) begin failures++; $display("FAIL txdata_read: read_data=0x%04h expected 0x0000", v); end
    wait_cycle(start + 10 * DIV);
    for (int i = 1; i < 17; i++) begin
      receive_frame(got, ok);
      checks++;
      if (got !== q[i] || ok !== 1'b1) begin
        failures++; $display("FAIL ovf_frame%0d: got=0x%02h shape=%b expected 0x%02h shape=1", i, got, ok, q[i]);
      end
    end
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0002 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL ovf_drained: status=0x%04h busy=%b expected 0x0002 busy=0", v, tx_busy);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0]  b0, b1, b2, got;
    logic        ok;
    logic [15:0] v;
    int unsigned start;
    b0 = 8'($urandom());
    b1 = 8'($urandom());
    b2 = 8'($urandom());
    cpu_write(2'd0, b0);
    start = cyc + 1;
    cpu_write(2'd0, b1);
    fork
      receive_frame(got, ok);
      begin
        // Land the push on the edge that ends frame 0's stop bit.
        wait_cycle(start + 10 * DIV - 1);
        cpu_write(2'd0, b2);
      end
    join
    checks++;
    if (got !== b0 || ok !== 1'b1) begin
      failures++; $display("FAIL sim_frame0: got=0x%02h shape=%b expected 0x%02h shape=1", got, ok, b0);
    end
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0008) begin failures++; $display("FAIL sim_count: status=0x%04h expected 0x0008", v); end
    receive_frame(got, ok);
    checks++;
    if (got !== b1 || ok !== 1'b1) begin
      failures++; $display("FAIL sim_frame1: got=0x%02h shape=%b expected 0x%02h shape=1", got, ok, b1);
    end
    receive_frame(got, ok);
    checks++;
    if (got !== b2 || ok !== 1'b1) begin
      failures++; $display("FAIL sim_frame2: got=0x%02h shape=%b expected 0x%02h shape=1", got, ok, b2);
    end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL sim_idle: tx_busy=%b expected 0", tx_busy); end
  endtask

  task automatic test_mid_reset();
    logic [7:0]  b;
    logic [15:0] v;
    logic        quiet;
    int unsigned start;
    b = 8'($urandom()) & 8'hF7;
    cpu_write(2'd0, b);
    start = cyc + 1;
    cpu_write(2'd0, 8'($urandom()));
    // Slot 4 of the frame carries data bit 3, which is forced to 0.
    wait_cycle(start + 4 * DIV + 3);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL midrst_bit3: tx=%b expected 0", tx); end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL midrst_async: tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy);
    end
    cpu_read(2'd1, v);
    reset = 1'b1;
    checks++;
    if (v !== 16'h0002) begin failures++; $display("FAIL midrst_status: status=0x%04h expected 0x0002", v); end
    quiet = 1'b1;
    repeat (12 * DIV) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin failures++; $display("FAIL midrst_quiet: line_quiet=%b expected 1", quiet); end
    cpu_read(2'd1, v);
    checks++;
    if (v !== 16'h0002) begin failures++; $display("FAIL midrst_after: status=0x%04h expected 0x0002", v); end
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_single(8'($urandom()));
    test_back_to_back(8'hA3, 8'h0F);
    test_back_to_back(8'($urandom()), 8'($urandom()));
    test_overflow();
    test_simultaneous();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
